// File: rtl/debnc_pkg.sv
// ---------------------------------------------------------------------------
// debnc_pkg
//
// Shared types and elaboration-time helpers for the multi-channel debouncer.
//
// Contents:
//   chan_out_t    - per-channel registered outputs (level, rise, fall, rpt)
//   cnt_width()   - counter width helper: $clog2(n), never narrower than 1 bit
//   params_legal()- parameter legality test, evaluated at elaboration time
// ---------------------------------------------------------------------------
package debnc_pkg;

  // Everything one channel drives toward the output buses. Bundling the
  // fields keeps the top-level bus assembly to one connection per channel.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic rpt;
  } chan_out_t;

  // Width of a counter that must hold values 0 .. n-1. A degenerate count
  // still needs one bit so that every vector has a legal range.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // A debounce window below 2 cycles is no filter at all. A single
  // synchroniser flop gives no metastability protection. A zero repeat
  // period would repeat every cycle with no gap.
  function automatic bit params_legal(input int channels,
                                      input int time_out,
                                      input int sync_stages,
                                      input int repeat_period);
    return (channels >= 1) && (time_out >= 2) &&
           (sync_stages >= 2) && (repeat_period >= 1);
  endfunction

endpackage : debnc_pkg

// File: rtl/debnc_chan.sv
// ---------------------------------------------------------------------------
// debnc_chan
//
// One debouncer channel. It contains:
//   - a SyncStages-deep synchroniser for the raw asynchronous pin,
//   - a stability counter that accepts a new level only after TimeOut
//     consecutive cycles of disagreement with the current output,
//   - registered one-cycle rise/fall pulses,
//   - an optional auto-repeat counter (RepeatDelay = 0 disables it).
//
// Ports:
//   clock   in   sole clock, rising edge
//   reset   in   asynchronous, active-high reset
//   sigin   in   raw asynchronous input pin
//   chan_o  out  registered level / rise / fall / rpt for this channel
// ---------------------------------------------------------------------------
module debnc_chan
  import debnc_pkg::*;
#(
  parameter int TimeOut      = 64,
  parameter bit Inverted     = 1'b0,
  parameter int SyncStages   = 2,
  parameter int RepeatDelay  = 0,
  parameter int RepeatPeriod = 16
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      sigin,
  output chan_out_t chan_o
);

  localparam int CntW   = cnt_width(TimeOut);
  localparam int RepMax = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
  localparam int RcntW  = cnt_width(RepMax);

  localparam logic [CntW-1:0]  CntLast  = CntW'(TimeOut - 1);
  // The repeat counter counts down to zero and fires on the edge after it
  // reaches zero, so loading N-1 gives a pulse exactly N edges later.
  localparam logic [RcntW-1:0] RepFirst = RcntW'((RepeatDelay > 0) ? (RepeatDelay - 1) : 0);
  localparam logic [RcntW-1:0] RepNext  = RcntW'(RepeatPeriod - 1);
  localparam bit               RepOn    = (RepeatDelay > 0);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [RcntW-1:0]      rcnt_q, rcnt_d;
  logic                  level_q, level_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  rpt_q, rpt_d;

  logic sample;
  logic differs;
  logic accept;

  // Synchroniser shift chain; new pin value enters at bit 0 and the oldest
  // (most settled) copy sits at the top bit.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], sigin};
  end

  // Debounce counter. The count only ever runs while the synchronised
  // sample disagrees with the accepted level; any agreement, even for a
  // single cycle, throws the partial count away.
  always_comb begin
    sample  = sync_q[SyncStages-1] ^ Inverted;
    differs = (sample != level_q);
    accept  = differs && (cnt_q == CntLast);

    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (differs) begin
      if (accept) begin
        level_d = sample;
        rise_d  = sample;
        fall_d  = ~sample;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Auto-repeat. The load happens on the same edge that raises level_q,
  // so rpt can never coincide with rise. The fall edge is excluded
  // explicitly so a counter that happens to expire then stays silent.
  always_comb begin
    rcnt_d = rcnt_q;
    rpt_d  = 1'b0;

    if (!RepOn) begin
      rcnt_d = '0;
    end else if (accept && sample) begin
      rcnt_d = RepFirst;
    end else if (accept && !sample) begin
      rcnt_d = '0;
    end else if (level_q) begin
      if (rcnt_q == '0) begin
        rpt_d  = 1'b1;
        rcnt_d = RepNext;
      end else begin
        rcnt_d = rcnt_q - RcntW'(1);
      end
    end
  end

  // State register. Synchroniser flops come out of reset at the
  // logically inactive pin level, so an idle pin produces no edge when
  // reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= {SyncStages{Inverted}};
      cnt_q   <= '0;
      rcnt_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rpt_q   <= rpt_d;
    end
  end

  always_comb begin
    chan_o.level = level_q;
    chan_o.rise  = rise_q;
    chan_o.fall  = fall_q;
    chan_o.rpt   = rpt_q;
  end

endmodule : debnc_chan

// File: rtl/debnc_multi.sv
// ---------------------------------------------------------------------------
// debnc_multi
//
// Parametrised multi-channel debouncer. Each of the Channels raw pins is
// synchronised and debounced independently by its own debnc_chan; this
// level only replicates the channel and gathers the per-channel results
// into output buses. Events on different channels in the same cycle are
// all reported together.
//
// The auto-repeat output is named rpt because "repeat" is a reserved word
// in SystemVerilog.
//
// Ports:
//   clock   in   sole clock, rising edge
//   reset   in   asynchronous, active-high reset
//   sigin   in   [Channels] raw asynchronous inputs
//   sigout  out  [Channels] debounced logical level (active-high)
//   rise    out  [Channels] one-cycle pulse on accepted 0->1
//   fall    out  [Channels] one-cycle pulse on accepted 1->0
//   rpt     out  [Channels] one-cycle auto-repeat pulse while held
// ---------------------------------------------------------------------------
module debnc_multi
  import debnc_pkg::*;
#(
  parameter int Channels     = 8,
  parameter int TimeOut      = 64,
  parameter bit Inverted     = 1'b0,
  parameter int SyncStages   = 2,
  parameter int RepeatDelay  = 0,
  parameter int RepeatPeriod = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [Channels-1:0] sigin,
  output logic [Channels-1:0] sigout,
  output logic [Channels-1:0] rise,
  output logic [Channels-1:0] fall,
  output logic [Channels-1:0] rpt
);

  // Refuse to elaborate with parameters that would silently break the
  // filter rather than produce a subtly wrong debouncer.
  if (!params_legal(Channels, TimeOut, SyncStages, RepeatPeriod)) begin : g_bad_params
    $error("debnc_multi: illegal parameters (need Channels>=1, TimeOut>=2, SyncStages>=2, RepeatPeriod>=1)");
  end

  for (genvar i = 0; i < Channels; i++) begin : g_chan
    chan_out_t chan_out;

    debnc_chan #(
      .TimeOut     (TimeOut),
      .Inverted    (Inverted),
      .SyncStages  (SyncStages),
      .RepeatDelay (RepeatDelay),
      .RepeatPeriod(RepeatPeriod)
    ) u_chan (
      .clock (clock),
      .reset (reset),
      .sigin (sigin[i]),
      .chan_o(chan_out)
    );

    assign sigout[i] = chan_out.level;
    assign rise[i]   = chan_out.rise;
    assign fall[i]   = chan_out.fall;
    assign rpt[i]    = chan_out.rpt;
  end

endmodule : debnc_multi

// File: tb/tb_debnc_multi.sv
// ---------------------------------------------------------------------------
// tb_debnc_multi
//
// Drives two debnc_multi instances from the same stimulus: one with
// active-high pins and one with active-low pins fed the inverted stimulus.
// Both must produce the same logical outputs. Expected events are queued
// with the edge number on which they must appear when stimulus is driven,
// and a negedge monitor pops and compares them against both instances.
// ---------------------------------------------------------------------------
module tb_debnc_multi;

  localparam int Channels     = 8;
  localparam int TimeOut      = 64;
  localparam int SyncStages   = 2;
  localparam int RepeatDelay  = 100;
  localparam int RepeatPeriod = 20;
  // Edges from the drive-time edge count to the edge that shows the output.
  localparam int Lat          = SyncStages + TimeOut;

  typedef enum logic [1:0] {K_RISE, K_FALL, K_RPT} kind_t;
  typedef struct {
    int    cyc;
    kind_t kind;
    int    ch;
  } exp_t;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [Channels-1:0] sigin = '0;
  logic [Channels-1:0] sigin_inv;
  logic [Channels-1:0] sigout_a, rise_a, fall_a, rpt_a;
  logic [Channels-1:0] sigout_b, rise_b, fall_b, rpt_b;

  exp_t                exp_q[$];
  logic [Channels-1:0] exp_level = '0;
  int                  edge_n = 0;
  int                  errors = 0;
  int                  checks = 0;
  bit                  mon_en = 1'b0;

  assign sigin_inv = ~sigin;

  debnc_multi #(
    .Channels(Channels), .TimeOut(TimeOut), .Inverted(1'b0),
    .SyncStages(SyncStages), .RepeatDelay(RepeatDelay), .RepeatPeriod(RepeatPeriod)
  ) dut_a (
    .clock(clock), .reset(reset), .sigin(sigin),
    .sigout(sigout_a), .rise(rise_a), .fall(fall_a), .rpt(rpt_a)
  );

  debnc_multi #(
    .Channels(Channels), .TimeOut(TimeOut), .Inverted(1'b1),
    .SyncStages(SyncStages), .RepeatDelay(RepeatDelay), .RepeatPeriod(RepeatPeriod)
  ) dut_b (
    .clock(clock), .reset(reset), .sigin(sigin_inv),
    .sigout(sigout_b), .rise(rise_b), .fall(fall_b), .rpt(rpt_b)
  );

  always #5 clock = ~clock;

  // Edge counter: at a negedge, edge_n is the number of the posedge just seen.
  always @(posedge clock) edge_n <= edge_n + 1;

  // Insert an expectation keeping the queue ordered by due edge.
  function automatic void push_exp(input int cyc, input kind_t kind, input int ch);
    exp_t e;
    int   pos;
    e.cyc  = cyc;
    e.kind = kind;
    e.ch   = ch;
    pos    = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc > cyc) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
  endfunction

  // Expected events for a press driven at edge count d_press and released at
  // d_release: rise, repeats strictly before the fall edge, then fall. Without
  // a fall, repeats are queued up to the release horizon and later flushed.
  function automatic void push_hold(input int ch, input int d_press,
                                    input int d_release, input bit with_fall);
    int rise_c;
    int fall_c;
    rise_c = d_press + Lat;
    fall_c = d_release + Lat;
    push_exp(rise_c, K_RISE, ch);
    for (int c = rise_c + RepeatDelay; c < fall_c; c += RepeatPeriod)
      push_exp(c, K_RPT, ch);
    if (with_fall) push_exp(fall_c, K_FALL, ch);
  endfunction

  // Scoreboard: pop everything due on this edge and compare both instances.
  always @(negedge clock) begin : monitor
    exp_t                e;
    logic [Channels-1:0] er, ef, ep;
    if (mon_en && !reset) begin
      er = '0;
      ef = '0;
      ep = '0;
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missed_event ch=%0d kind=%s due=%0d now=%0d",
                 e.ch, e.kind.name(), e.cyc, edge_n);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_RISE: begin er[e.ch] = 1'b1; exp_level[e.ch] = 1'b1; end
          K_FALL: begin ef[e.ch] = 1'b1; exp_level[e.ch] = 1'b0; end
          default: ep[e.ch] = 1'b1;
        endcase
      end
      checks++;
      if ({sigout_a, rise_a, fall_a, rpt_a} !== {exp_level, er, ef, ep}) begin
        errors++;
        $display("[TB] FAIL scoreboard_a edge=%0d got lvl/r/f/p=%h/%h/%h/%h need %h/%h/%h/%h",
                 edge_n, sigout_a, rise_a, fall_a, rpt_a, exp_level, er, ef, ep);
      end
      checks++;
      if ({sigout_b, rise_b, fall_b, rpt_b} !== {exp_level, er, ef, ep}) begin
        errors++;
        $display("[TB] FAIL scoreboard_b edge=%0d got lvl/r/f/p=%h/%h/%h/%h need %h/%h/%h/%h",
                 edge_n, sigout_b, rise_b, fall_b, rpt_b, exp_level, er, ef, ep);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    sigin = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({sigout_a, rise_a, fall_a, rpt_a} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_a got=%h need=0", {sigout_a, rise_a, fall_a, rpt_a});
    end
    checks++;
    if ({sigout_b, rise_b, fall_b, rpt_b} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_b got=%h need=0", {sigout_b, rise_b, fall_b, rpt_b});
    end
    reset  = 1'b0;
    mon_en = 1'b1;
    // Idle pins after release must not produce any event.
    repeat (100) @(negedge clock);
    checks++;
    if (sigout_a !== '0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle got=%h need=0", sigout_a);
    end
  endtask

  task automatic test_bounce_burst();
    for (int t = 0; t < 2000; t++) begin
      @(negedge clock);
      sigin = (((t % 233) < 20) && ((t % 5) > 2)) ? '1 : '0;
    end
    @(negedge clock);
    sigin = '0;
    repeat (80) @(negedge clock);
    checks++;
    if (sigout_a !== '0 || sigout_b !== '0) begin
      errors++;
      $display("[TB] FAIL bounce_burst got a=%h b=%h need=0", sigout_a, sigout_b);
    end
  endtask

  task automatic test_clean_press();
    int d;
    @(negedge clock);
    d = edge_n;
    sigin[0] = 1'b1;
    push_hold(0, d, d + 200, 1'b1);
    repeat (Lat - 1) @(negedge clock);
    checks++;
    if (sigout_a[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL press_early edge=%0d got=%b need=0", edge_n, sigout_a[0]);
    end
    @(negedge clock);
    checks++;
    if (sigout_a[0] !== 1'b1 || rise_a[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL press_on_time edge=%0d got lvl=%b rise=%b need 1/1",
               edge_n, sigout_a[0], rise_a[0]);
    end
    repeat (200 - Lat) @(negedge clock);
    sigin[0] = 1'b0;
    repeat (Lat) @(negedge clock);
    checks++;
    if (sigout_a[0] !== 1'b0 || fall_a[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release_on_time edge=%0d got lvl=%b fall=%b need 0/1",
               edge_n, sigout_a[0], fall_a[0]);
    end
    repeat (20) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL clean_press_pending got=%0d need=0", exp_q.size());
    end
  endtask

  task automatic test_bounce_settle();
    int d;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      sigin[3] = (i % 2 == 0);
    end
    @(negedge clock);
    d = edge_n;
    sigin[3] = 1'b1;
    push_hold(3, d, d + 150, 1'b1);
    repeat (150) @(negedge clock);
    sigin[3] = 1'b0;
    repeat (Lat + 20) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || sigout_a[3] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bounce_settle pending=%0d lvl=%b need 0/0", exp_q.size(), sigout_a[3]);
    end
  endtask

  task automatic test_auto_repeat();
    int d;
    int rpt_seen;
    rpt_seen = 0;
    @(negedge clock);
    d = edge_n;
    sigin[5] = 1'b1;
    sigin[1] = 1'b1;
    push_hold(5, d, d + 370, 1'b1);
    push_hold(1, d, d + 100, 1'b1);
    for (int i = 1; i <= 470; i++) begin
      @(negedge clock);
      if (rpt_a[5]) rpt_seen++;
      if (i == 100) sigin[1] = 1'b0;
      if (i == 370) sigin[5] = 1'b0;
    end
    // Rise at d+66, fall at d+436: repeats at d+166, +186, ... , d+426.
    checks++;
    if (rpt_seen != 14) begin
      errors++;
      $display("[TB] FAIL repeat_count got=%0d need=14", rpt_seen);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL auto_repeat_pending got=%0d need=0", exp_q.size());
    end
  endtask

  task automatic test_glitch_boundary();
    int d;
    // One cycle short of the window: nothing may happen.
    @(negedge clock);
    sigin[7] = 1'b1;
    repeat (TimeOut - 1) @(negedge clock);
    sigin[7] = 1'b0;
    repeat (100) @(negedge clock);
    checks++;
    if (sigout_a[7] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_short got=%b need=0", sigout_a[7]);
    end
    // Exactly the window: accepted, then released again.
    d = edge_n;
    sigin[7] = 1'b1;
    push_hold(7, d, d + TimeOut, 1'b1);
    repeat (TimeOut) @(negedge clock);
    sigin[7] = 1'b0;
    repeat (TimeOut + Lat + 10) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL glitch_exact_pending got=%0d need=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int d6;
    int dr;
    @(negedge clock);
    d6 = edge_n;
    sigin[6] = 1'b1;
    push_hold(6, d6, d6 + 400, 1'b0);
    repeat (Lat + 125) @(negedge clock);
    // Channel 2 starts counting; channel 6 is already repeating.
    sigin[2] = 1'b1;
    repeat (41) @(negedge clock);
    checks++;
    if (sigout_a[6] !== 1'b1 || sigout_a[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pre_reset got=%h need=40", sigout_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({sigout_a, rise_a, fall_a, rpt_a, sigout_b, rise_b, fall_b, rpt_b} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_count got a=%h b=%h need=0",
               {sigout_a, rise_a, fall_a, rpt_a}, {sigout_b, rise_b, fall_b, rpt_b});
    end
    exp_q.delete();
    exp_level = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    dr = edge_n;
    push_hold(2, dr, dr + 400, 1'b0);
    push_hold(6, dr, dr + 400, 1'b0);
    repeat (Lat - 1) @(negedge clock);
    checks++;
    if (sigout_a[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fresh_delay_early edge=%0d got=%b need=0", edge_n, sigout_a[2]);
    end
    repeat (126) @(negedge clock);
    // Repeats at dr+166 and dr+186 have passed; reset mid-repeat.
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({sigout_a, rise_a, fall_a, rpt_a, sigout_b, rise_b, fall_b, rpt_b} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_repeat got a=%h b=%h need=0",
               {sigout_a, rise_a, fall_a, rpt_a}, {sigout_b, rise_b, fall_b, rpt_b});
    end
    exp_q.delete();
    exp_level = '0;
    sigin = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    checks++;
    if (sigout_a !== '0 || sigout_b !== '0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got a=%h b=%h need=0", sigout_a, sigout_b);
    end
  endtask

  initial begin
    $display("[TB] debnc_multi bench start");
    test_reset();
    test_bounce_burst();
    test_clean_press();
    test_bounce_settle();
    test_auto_repeat();
    test_glitch_boundary();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_debnc_multi
